serial_frame_rx: RTL and testbench

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_rx.sv | 148 ++++++++++++++
 tb/tb_serial_frame_rx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, even parity, stop bit.
// A completed frame is held in data_out/parity_err under a valid/ready handshake.
module serial_frame_rx #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             si,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             parity_err,
    output logic             framing_err,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic             r_par;
    logic             w_par_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_perr;
    logic             w_perr_nxt;
    logic             r_ferr;
    logic             w_ferr_nxt;
    logic             r_ovr;
    logic             w_ovr_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             w_accept;

    // Downstream takes the held frame this edge.
    assign w_accept = r_valid & ready;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_par   <= 1'b0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_par   <= w_par_nxt;
            r_valid <= w_valid_nxt;
            r_perr  <= w_perr_nxt;
            r_ferr  <= w_ferr_nxt;
            r_ovr   <= w_ovr_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state and next-value logic for the frame FSM and output holding register.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_par_nxt   = r_par;
        w_perr_nxt  = r_perr;
        w_valid_nxt = r_valid & ~w_accept;
        w_ferr_nxt  = 1'b0;
        w_ovr_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!si) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                end
            end
            S_DATA: begin
                // LSB arrives first, so shift in from the top.
                w_shift_nxt = {si, r_shift[WIDTH-1:1]};
                w_cnt_nxt   = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_nxt = S_PARITY;
                end
            end
            S_PARITY: begin
                w_par_nxt   = si;
                w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (si) begin
                    w_state_nxt = S_IDLE;
                    // Load is allowed when the holding slot is empty or being emptied now.
                    if (!r_valid || ready) begin
                        w_data_nxt  = r_shift;
                        w_perr_nxt  = (^r_shift) ^ r_par;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_ovr_nxt = 1'b1;
                    end
                end else begin
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                // A line still low after a bad stop is not a new start bit.
                if (si) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign data_out    = r_data;
    assign valid       = r_valid;
    assign parity_err  = r_perr;
    assign framing_err = r_ferr;
    assign overrun     = r_ovr;
    assign busy        = r_busy;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames followed by randomized frames
// checked against a frame-level model of the receive/handshake rules.
module tb_serial_frame_rx;

    localparam int unsigned W = 6;

    logic         clk;
    logic         reset;
    logic         si;
    logic         ready;
    logic [W-1:0] data_out;
    logic         valid;
    logic         parity_err;
    logic         framing_err;
    logic         overrun;
    logic         busy;

    int n_checks;
    int n_errors;

    // Frame-level model of the holding register.
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_perr;

    serial_frame_rx #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .si         (si),
        .ready      (ready),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .framing_err(framing_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one complete frame; returns how many cycles busy was seen high before the stop edge.
    task automatic send_frame(input logic [W-1:0] d, input logic par, input logic stop,
                              output int busy_cnt);
        busy_cnt = 0;
        si = 1'b0;
        tick();
        if (busy) busy_cnt++;
        for (int i = 0; i < int'(W); i++) begin
            si = d[i];
            tick();
            if (busy) busy_cnt++;
        end
        si = par;
        tick();
        if (busy) busy_cnt++;
        si = stop;
        tick();
        si = 1'b1;
    endtask

    function automatic logic even_par(input logic [W-1:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < int'(W); i++) ones += int'(d[i]);
        return (ones % 2) != 0;
    endfunction

    initial begin
        int           bc;
        logic [W-1:0] d;
        logic         p;
        logic         stop_ok;
        logic         par_bad;
        logic         r;
        int           gap;
        logic         exp_ovr;

        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        si       = 1'b1;
        ready    = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ferr", 32'(framing_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        reset = 1'b1;

        // Basic good frame 6'h2D, correct parity.
        send_frame(6'h2D, 1'b0, 1'b1, bc);
        chk("f1_busy_cycles", 32'(bc), 32'd8);
        chk("f1_busy_after", 32'(busy), 32'd0);
        chk("f1_valid", 32'(valid), 32'd1);
        chk("f1_data", 32'(data_out), 32'h2D);
        chk("f1_perr", 32'(parity_err), 32'd0);
        ready = 1'b1;
        tick();
        chk("f1_accept", 32'(valid), 32'd0);
        ready = 1'b0;

        // Parity error frame.
        send_frame(6'h2D, 1'b1, 1'b1, bc);
        chk("f2_valid", 32'(valid), 32'd1);
        chk("f2_data", 32'(data_out), 32'h2D);
        chk("f2_perr", 32'(parity_err), 32'd1);
        ready = 1'b1;
        tick();
        chk("f2_accept", 32'(valid), 32'd0);
        ready = 1'b0;

        // Overrun: second frame dropped while first is held.
        send_frame(6'h2D, 1'b0, 1'b1, bc);
        chk("ov_first_ovr", 32'(overrun), 32'd0);
        send_frame(6'h15, 1'b1, 1'b1, bc);
        chk("ov_pulse", 32'(overrun), 32'd1);
        chk("ov_data_kept", 32'(data_out), 32'h2D);
        chk("ov_perr_kept", 32'(parity_err), 32'd0);
        chk("ov_valid", 32'(valid), 32'd1);
        tick();
        chk("ov_pulse_end", 32'(overrun), 32'd0);
        ready = 1'b1;
        tick();
        chk("ov_accept", 32'(valid), 32'd0);
        ready = 1'b0;

        // Framing error, line held low, then a good frame.
        send_frame(6'h2A, 1'b1, 1'b0, bc);
        chk("fe_pulse", 32'(framing_err), 32'd1);
        chk("fe_valid", 32'(valid), 32'd0);
        si = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fe_low_ferr", 32'(framing_err), 32'd0);
            chk("fe_low_valid", 32'(valid), 32'd0);
        end
        si = 1'b1;
        tick();
        chk("fe_idle_busy", 32'(busy), 32'd0);
        send_frame(6'h01, 1'b1, 1'b1, bc);
        chk("fe_good_valid", 32'(valid), 32'd1);
        chk("fe_good_data", 32'(data_out), 32'h01);
        chk("fe_good_perr", 32'(parity_err), 32'd0);
        ready = 1'b1;
        tick();
        chk("fe_accept", 32'(valid), 32'd0);

        // Back-to-back frames with ready held high.
        send_frame(6'h2D, 1'b0, 1'b1, bc);
        chk("b2b_v1", 32'(valid), 32'd1);
        chk("b2b_d1", 32'(data_out), 32'h2D);
        chk("b2b_o1", 32'(overrun), 32'd0);
        send_frame(6'h3F, 1'b0, 1'b1, bc);
        chk("b2b_busy2", 32'(bc), 32'd8);
        chk("b2b_v2", 32'(valid), 32'd1);
        chk("b2b_d2", 32'(data_out), 32'h3F);
        chk("b2b_o2", 32'(overrun), 32'd0);
        chk("b2b_p2", 32'(parity_err), 32'd0);
        tick();
        chk("b2b_accept", 32'(valid), 32'd0);
        ready = 1'b0;

        // Reset in mid-frame abandons it.
        si = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            si = 1'(i % 2);
            tick();
        end
        reset = 1'b0;
        si    = 1'b1;
        tick();
        chk("mr_valid", 32'(valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mr_quiet", 32'({valid, framing_err, overrun, busy}), 32'd0);
        end
        send_frame(6'h2D, 1'b0, 1'b1, bc);
        chk("mr_valid2", 32'(valid), 32'd1);
        chk("mr_data2", 32'(data_out), 32'h2D);
        ready = 1'b1;
        tick();
        chk("mr_accept", 32'(valid), 32'd0);

        // Randomized frames against the frame-level model.
        m_valid = 1'b0;
        m_data  = 6'h2D;
        m_perr  = 1'b0;
        for (int f = 0; f < 60; f++) begin
            d       = W'($urandom_range(0, (1 << W) - 1));
            par_bad = ($urandom_range(0, 3) == 0);
            stop_ok = ($urandom_range(0, 4) != 0);
            r       = 1'($urandom_range(0, 1));
            gap     = int'($urandom_range(0, 2));
            p       = even_par(d) ^ par_bad;
            ready   = r;
            si      = 1'b1;
            for (int g = 0; g < gap; g++) tick();
            // With ready held, a held frame is taken at the first edge of this frame.
            if (r) m_valid = 1'b0;
            exp_ovr = 1'b0;
            send_frame(d, p, stop_ok, bc);
            chk("rnd_busy", 32'(bc), 32'd8);
            if (stop_ok) begin
                if (!m_valid) begin
                    m_valid = 1'b1;
                    m_data  = d;
                    m_perr  = par_bad;
                end else begin
                    exp_ovr = 1'b1;
                end
            end
            chk("rnd_valid", 32'(valid), 32'(m_valid));
            chk("rnd_data", 32'(data_out), 32'(m_data));
            chk("rnd_perr", 32'(parity_err), 32'(m_perr));
            chk("rnd_ovr", 32'(overrun), 32'(exp_ovr));
            chk("rnd_ferr", 32'(framing_err), 32'(!stop_ok));
            if (!stop_ok) begin
                si = 1'b0;
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
                si = 1'b1;
                tick();
                chk("rnd_fe_idle", 32'(busy), 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
